// File: rtl/io_bus_responder.sv
// io_bus_responder: memory-mapped I/O register file that answers shared-bus transactions after LAT cycles.
// Optional feature: define IO_BUS_ERR_EN to flag out-of-range accesses with err instead of aliasing them.
module io_bus_responder #(
  parameter int NREGS = 16,
  parameter int LAT   = 3
) (
  input  logic        clk_i,
  input  logic        reset_i,
  input  logic        en_i,
  input  logic        rd_wr_i,
  input  logic [31:0] addr_i,
  input  logic [1:0]  wr_size_i,
  input  logic [31:0] data_in_i,
  output logic [31:0] data_out_o,
  output logic        data_oe_o,
  output logic        ready_o,
  output logic        err_o
);

  localparam int IW = $clog2(NREGS);

  typedef enum logic [1:0] {IDLE, WAIT, RESP, HOLD} state_t;

  state_t        state_q;
  logic [3:0]    cnt_q;
  logic [IW+1:0] addr_q;
  logic          wr_q;
  logic [1:0]    size_q;
  logic          oor_q;
  logic [31:0]   regs_q [NREGS];
  logic          ready_q;
  logic          oe_q;
  logic [31:0]   dout_q;

  logic          oor_in;
  logic [IW+1:0] sel_addr;
  logic          sel_wr;
  logic          sel_oor;
  logic [31:0]   rd_word;
  logic [31:0]   reg_wr_d;
  logic [2:0]    nbytes;
  logic          enter_resp;

`ifdef IO_BUS_ERR_EN
  logic err_q;
  assign oor_in = |addr_i[31:IW+2];
  assign err_o  = err_q;
`else
  // Upper address bits are ignored so the register file aliases across the whole window.
  logic unused_addr;
  assign unused_addr = &{1'b0, addr_i[31:IW+2]};
  assign oor_in      = 1'b0;
  assign err_o       = 1'b0;
`endif

  assign data_out_o = dout_q;
  assign data_oe_o  = oe_q;
  assign ready_o    = ready_q;

  // With LAT=1 the response is built straight from the bus, otherwise from the latched request.
  always_comb begin
    if (state_q == IDLE) begin
      sel_addr = addr_i[IW+1:0];
      sel_wr   = rd_wr_i;
      sel_oor  = oor_in;
    end else begin
      sel_addr = addr_q;
      sel_wr   = wr_q;
      sel_oor  = oor_q;
    end
    rd_word    = regs_q[sel_addr[IW+1:2]] >> {sel_addr[1:0], 3'b000};
    enter_resp = en_i && (((state_q == IDLE) && (LAT == 1)) ||
                          ((state_q == WAIT) && (cnt_q == 4'd1)));
  end

  // Byte lanes past byte 3 fall off the end instead of wrapping into the next register.
  always_comb begin
    case (size_q)
      2'b00:   nbytes = 3'd1;
      2'b01:   nbytes = 3'd2;
      default: nbytes = 3'd4;
    endcase
    reg_wr_d = regs_q[addr_q[IW+1:2]];
    for (int k = 0; k < 4; k++) begin
      if ((k < int'(nbytes)) && ((int'(addr_q[1:0]) + k) < 4)) begin
        reg_wr_d[8*(int'(addr_q[1:0]) + k) +: 8] = data_in_i[8*k +: 8];
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      wr_q    <= 1'b0;
      size_q  <= '0;
      oor_q   <= 1'b0;
      ready_q <= 1'b0;
      oe_q    <= 1'b0;
      dout_q  <= '0;
`ifdef IO_BUS_ERR_EN
      err_q   <= 1'b0;
`endif
      for (int i = 0; i < NREGS; i++) begin
        regs_q[i] <= '0;
      end
    end else begin
      ready_q <= 1'b0;
      oe_q    <= 1'b0;
      dout_q  <= '0;
`ifdef IO_BUS_ERR_EN
      err_q   <= 1'b0;
`endif
      case (state_q)
        IDLE: begin
          if (en_i) begin
            addr_q  <= addr_i[IW+1:0];
            wr_q    <= rd_wr_i;
            size_q  <= wr_size_i;
            oor_q   <= oor_in;
            cnt_q   <= 4'(LAT - 1);
            state_q <= (LAT == 1) ? RESP : WAIT;
          end
        end
        WAIT: begin
          if (!en_i) begin
            state_q <= IDLE;
          end else begin
            cnt_q <= cnt_q - 4'd1;
            if (cnt_q == 4'd1) begin
              state_q <= RESP;
            end
          end
        end
        RESP: begin
          if (wr_q && !oor_q) begin
            regs_q[addr_q[IW+1:2]] <= reg_wr_d;
          end
          state_q <= en_i ? HOLD : IDLE;
        end
        HOLD: begin
          if (!en_i) begin
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
      if (enter_resp) begin
        ready_q <= 1'b1;
        oe_q    <= !sel_wr;
        dout_q  <= (!sel_wr && !sel_oor) ? rd_word : 32'h0;
`ifdef IO_BUS_ERR_EN
        err_q   <= sel_oor;
`endif
      end
    end
  end

endmodule

// File: doc/io_bus_responder.md
# io_bus_responder

Memory-mapped I/O register device that answers transactions on the shared 32-bit memory-subsystem bus. It responds when the arbiter decoder raises its I/O enable, which happens alongside main memory responding to memory enables. Bus masters (icache, dcache, system read master) drive address, direction and write size; this block returns read data or commits write data after a fixed access latency and signals completion on `ready`. It fills the currently unpopulated I/O slot in the memory subsystem.

## Interface
- `NREGS`, 16: number of 32-bit registers; power of two, 2..64.
- `LAT`, 3: cycles from the first sampled `en` to `ready`; 1..15.
- `clk` in 1: single clock; all state updates on the rising edge.
- `reset` in 1: synchronous, active-high.
- `en` in 1: I/O enable from the decoder; held high by the master for the whole transaction.
- `rd_wr` in 1: 1 = write, 0 = read; sampled with `en`.
- `addr` in 32: byte address; `addr[1:0]` is the byte offset, `addr[log2(NREGS)+1:2]` is the register index, and upper bits are the range check.
- `wr_size` in 2: 00 = 1 byte, 01 = 2 bytes, 10/11 = 4 bytes.
- `data_in` in 32: write data, LSB-aligned (byte 0 in `[7:0]`).
- `data_out` out 32: read data; valid only while `data_oe` is high.
- `data_oe` out 1: bus drive enable; high only in the read-response cycle.
- `ready` out 1: one-cycle completion pulse (drives the bus data-valid signal).
- `err` out 1: access-error flag, valid with `ready`.

## Operation
- States: IDLE, WAIT, RESP, HOLD.
- IDLE:
  - On `en`=1, latch `addr`, `rd_wr`, `wr_size` and load the counter with LAT-1.
  - Go to RESP if LAT=1, otherwise go to WAIT.
- WAIT:
  - Decrement the counter each cycle.
  - When the counter reaches 0, go to RESP.
  - If `en`=0, abort to IDLE: no write, no `ready`.
- RESP (one cycle): `ready`=1.
  - Read: `data_out` = selected register shifted right by 8×offset, zero-filled; `data_oe`=1.
  - Write: the bytes from `data_in[8k+7:8k]` go to register byte offset+k, for k < size. Bytes past byte 3 are dropped; there is no wrap into the next register. The write commits at the edge that ends RESP, using `data_in` sampled in RESP.
  - After RESP, go to HOLD.
- HOLD: wait for `en`=0, then go to IDLE. A new transaction needs at least one cycle of `en` low; `en` held high across transactions never re-triggers.
- Latched address/direction/size are used throughout. Input changes after acceptance are ignored, except `data_in`, which is sampled in RESP.
- Out-of-range access means any address bit above the index field is set, or index ≥ NREGS. Behaviour depends on configuration.
- All registers are read/write, with no side effects.

## Timing
- Reset values:
  - State IDLE, counter 0.
  - `ready`=0, `data_oe`=0, `data_out`=0, `err`=0.
  - All registers 0x00000000.
- Reset asserted mid-transaction wins: return to IDLE the next cycle, no commit, no `ready`.
- Latency: `en` first sampled high at edge N puts `ready` high in the cycle following edge N+LAT-1.
- All outputs are registered; none depend combinationally on inputs.
- `data_out` is 0 whenever `data_oe`=0.
- `en` falling in the same cycle as RESP: the response still completes, and the next state is IDLE directly.

## Configuration
- `IO_BUS_ERR_EN` defined:
  - An out-of-range access still completes with `ready` after LAT, with `err`=1 in the RESP cycle.
  - Writes are discarded; reads drive `data_out`=0 with `data_oe`=1.
  - `err` is registered and cleared the next cycle.
- Not defined:
  - The register index is taken modulo NREGS and upper address bits are ignored (aliasing).
  - `err` is tied 0.

## Test plan
- Reset then read: read `addr`=0x8 with LAT=3 -> `ready` 3 cycles after `en`, `data_out`=0x00000000, `data_oe`=1 for exactly 1 cycle.
- Word write/readback: write 0xDEADBEEF, size 10, to 0x4, then read 0x4 -> 0xDEADBEEF. Read 0x6 -> 0x0000DEAD.
- Partial write:
  - Preload reg1 with 0x11223344.
  - Write 0xAB, size 00, at 0x5 -> reg1 = 0x1122AB44.
  - Write 0xCCDD, size 01, at 0x7 -> reg1 = 0xDD22AB44 (upper byte dropped).
- Abort and reset: drop `en` in WAIT -> no `ready`, register unchanged. Assert `reset` during WAIT -> IDLE the next cycle, all outputs 0.
- Back-to-back: hold `en` high for 10 cycles -> exactly one `ready`. After `en` is low for one cycle and then high again, a second `ready` arrives LAT cycles later.
- Out of range, NREGS=16, addr 0x40:
  - With `IO_BUS_ERR_EN`: `err`=1 with `ready`, read data 0, write discarded.
  - Without: the access aliases to reg0.
